// File: rtl/rr_lane_scheduler_if.sv
// Bundle of requester, lane and result signals around rr_lane_scheduler.
// The master modport is the scheduler's view; slave is the surrounding fabric.
interface rr_lane_scheduler_if #(
    parameter int NREQ = 5,
    parameter int WD   = 4,
    parameter int IDW  = 3
);
    logic [NREQ-1:0]    IN_VALID;
    logic [NREQ*WD-1:0] IN_DATA;
    logic [NREQ-1:0]    IN_READY;
    logic [WD-1:0]      LANE_IN;
    logic               LANE_START;
    logic [WD-1:0]      LANE_OUT;
    logic               OUT_VALID;
    logic [IDW-1:0]     OUT_ID;
    logic [WD-1:0]      OUT_DATA;
    logic               OUT_READY;

    modport master (
        input  IN_VALID, IN_DATA, LANE_OUT, OUT_READY,
        output IN_READY, LANE_IN, LANE_START, OUT_VALID, OUT_ID, OUT_DATA
    );

    modport slave (
        output IN_VALID, IN_DATA, LANE_OUT, OUT_READY,
        input  IN_READY, LANE_IN, LANE_START, OUT_VALID, OUT_ID, OUT_DATA
    );
endinterface

// File: rtl/rr_lane_scheduler.sv
// Fair round-robin arbiter feeding one shared transform lane; one transaction
// in flight at a time, result tagged with the owning requester index.
module rr_lane_scheduler #(
    parameter int NREQ = 5,
    parameter int WD   = 4,
    parameter int IDW  = 3,
    parameter int LAT  = 0
) (
    input logic               CLK,
    input logic               RST,
    rr_lane_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    localparam logic [2:0]     LAT_LAST = 3'(LAT);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_reg;
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic [2:0]      lat_cnt;
    logic [WD-1:0]   lane_reg;
    logic [NREQ-1:0] grant_onehot;
    logic            transfer;
    logic            issue_last;
    logic            out_valid_reg;
    logic [IDW-1:0]  out_id_reg;
    logic [WD-1:0]   out_data_reg;
    logic [WD-1:0]   req_word [NREQ];
    int              cand;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_word[i] = bus.IN_DATA[i*WD +: WD];
        end
    end

    // Search starts at ptr and wraps with an explicit compare, so NREQ need not be a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_found && bus.IN_VALID[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (state == IDLE && !RST && grant_found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    assign transfer   = |(bus.IN_VALID & grant_onehot);
    assign issue_last = (state == ISSUE) && (lat_cnt == LAT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (transfer)      state_nxt = ISSUE;
            ISSUE:   if (issue_last)    state_nxt = HOLD;
            HOLD:    if (bus.OUT_READY) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Reset drops any in-flight word; the lane result is captured on the last ISSUE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            ptr           <= '0;
            lat_cnt       <= '0;
            lane_reg      <= '0;
            id_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_id_reg    <= '0;
            out_data_reg  <= '0;
        end else begin
            state <= state_nxt;
            if (transfer) begin
                lane_reg <= req_word[grant_idx];
                id_reg   <= grant_idx;
                ptr      <= (grant_idx == ID_LAST) ? '0 : grant_idx + IDW'(1);
                lat_cnt  <= '0;
            end else if (state == ISSUE && !issue_last) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
            if (issue_last) begin
                out_data_reg  <= bus.LANE_OUT;
                out_id_reg    <= id_reg;
                out_valid_reg <= 1'b1;
            end else if (state == HOLD && bus.OUT_READY) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.IN_READY   = grant_onehot;
    assign bus.LANE_IN    = lane_reg;
    assign bus.LANE_START = (state == ISSUE) && (lat_cnt == 3'd0);
    assign bus.OUT_VALID  = out_valid_reg;
    assign bus.OUT_ID     = out_id_reg;
    assign bus.OUT_DATA   = out_data_reg;
endmodule

// File: tb/tb_rr_lane_scheduler.sv
// Bench for rr_lane_scheduler: a combinational-lane and a 2-cycle-lane instance
// share one stimulus stream and are checked against a transaction-timeline model.
module tb_rr_lane_scheduler;
    localparam int NREQ = 5;
    localparam int WD   = 4;
    localparam int IDW  = 3;
    localparam int LAT0 = 0;
    localparam int LAT1 = 2;

    logic               CLK = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    in_valid;
    logic [NREQ*WD-1:0] in_data;
    logic               out_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    rr_lane_scheduler_if #(.NREQ(NREQ), .WD(WD), .IDW(IDW)) bus0 ();
    rr_lane_scheduler_if #(.NREQ(NREQ), .WD(WD), .IDW(IDW)) bus1 ();

    assign bus0.IN_VALID  = in_valid;
    assign bus0.IN_DATA   = in_data;
    assign bus0.OUT_READY = out_ready;
    assign bus1.IN_VALID  = in_valid;
    assign bus1.IN_DATA   = in_data;
    assign bus1.OUT_READY = out_ready;

    logic [WD-1:0] lane_dly [LAT1];
    assign bus0.LANE_OUT = bus0.LANE_IN ^ 4'hF;
    always_ff @(posedge CLK) begin
        lane_dly[0] <= bus1.LANE_IN ^ 4'hF;
        lane_dly[1] <= lane_dly[0];
    end
    assign bus1.LANE_OUT = lane_dly[LAT1-1];

    rr_lane_scheduler #(.NREQ(NREQ), .WD(WD), .IDW(IDW), .LAT(LAT0)) dut0 (
        .CLK(CLK), .RST(rst), .bus(bus0.master));
    rr_lane_scheduler #(.NREQ(NREQ), .WD(WD), .IDW(IDW), .LAT(LAT1)) dut1 (
        .CLK(CLK), .RST(rst), .bus(bus1.master));

    logic [NREQ-1:0] obs_ready [2];
    logic [WD-1:0]   obs_lane_in [2];
    logic            obs_start [2];
    logic            obs_valid [2];
    logic [IDW-1:0]  obs_id [2];
    logic [WD-1:0]   obs_data [2];
    assign obs_ready[0] = bus0.IN_READY;   assign obs_ready[1] = bus1.IN_READY;
    assign obs_lane_in[0] = bus0.LANE_IN;  assign obs_lane_in[1] = bus1.LANE_IN;
    assign obs_start[0] = bus0.LANE_START; assign obs_start[1] = bus1.LANE_START;
    assign obs_valid[0] = bus0.OUT_VALID;  assign obs_valid[1] = bus1.OUT_VALID;
    assign obs_id[0] = bus0.OUT_ID;        assign obs_id[1] = bus1.OUT_ID;
    assign obs_data[0] = bus0.OUT_DATA;    assign obs_data[1] = bus1.OUT_DATA;

    // Model: m_age counts cycles since acceptance (0 = no word in the lane).
    int m_lat [2] = '{LAT0, LAT1};
    int m_ptr [2];
    int m_age [2];
    int m_id [2];
    int m_word [2];
    int m_lane_in [2];
    int m_out_valid [2];
    int m_out_id [2];
    int m_out_data [2];
    int grant_log [$];

    function automatic int rrPick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_age[k] = 0; m_id[k] = 0; m_word[k] = 0; m_lane_in[k] = 0;
            m_out_valid[k] = 0; m_out_id[k] = 0; m_out_data[k] = 0;
        end
    endtask

    task automatic checkOutput();
        int g;
        int exp_ready;
        for (int k = 0; k < 2; k++) begin
            g = rrPick(in_valid, m_ptr[k]);
            exp_ready = (!rst && m_age[k] == 0 && m_out_valid[k] == 0 && g >= 0) ? (1 << g) : 0;
            checkValue($sformatf("dut%0d IN_READY", k), 32'(obs_ready[k]), exp_ready);
            checkValue($sformatf("dut%0d LANE_START", k), 32'(obs_start[k]), (m_age[k] == 1) ? 1 : 0);
            checkValue($sformatf("dut%0d LANE_IN", k), 32'(obs_lane_in[k]), m_lane_in[k]);
            checkValue($sformatf("dut%0d OUT_VALID", k), 32'(obs_valid[k]), m_out_valid[k]);
            checkValue($sformatf("dut%0d OUT_ID", k), 32'(obs_id[k]), m_out_id[k]);
            checkValue($sformatf("dut%0d OUT_DATA", k), 32'(obs_data[k]), m_out_data[k]);
        end
        if ((obs_ready[0] & in_valid) != '0) begin
            for (int i = 0; i < NREQ; i++) if (obs_ready[0][i]) grant_log.push_back(i);
        end
    endtask

    task automatic advanceModel();
        int g;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ptr[k] = 0; m_age[k] = 0; m_lane_in[k] = 0;
                m_out_valid[k] = 0; m_out_id[k] = 0; m_out_data[k] = 0;
            end else if (m_out_valid[k] != 0) begin
                if (out_ready) m_out_valid[k] = 0;
            end else if (m_age[k] > 0) begin
                if (m_age[k] == m_lat[k] + 1) begin
                    m_out_valid[k] = 1;
                    m_out_id[k]    = m_id[k];
                    m_out_data[k]  = m_word[k] ^ 'hF;
                    m_age[k]       = 0;
                end else begin
                    m_age[k]++;
                end
            end else begin
                g = rrPick(in_valid, m_ptr[k]);
                if (g >= 0) begin
                    m_id[k]      = g;
                    m_word[k]    = int'(in_data[g*WD +: WD]);
                    m_lane_in[k] = m_word[k];
                    m_ptr[k]     = (g + 1) % NREQ;
                    m_age[k]     = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v,
                                 input logic [NREQ*WD-1:0] d, input logic o);
        rst = r; in_valid = v; in_data = d; out_ready = o;
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            checkOutput();
            advanceModel();
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [NREQ*WD-1:0] d;
        int exp_order [7] = '{0, 1, 2, 3, 4, 0, 1};

        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        resetModel();
        @(posedge CLK);
        #1;
        applyStimulus(1'b1, '0, '0, 1'b0);
        runCycles(2);

        d = 20'h00300;
        applyStimulus(1'b0, 5'b00100, d, 1'b1);
        checkValue("t1 grant", 32'(bus0.IN_READY), 32'b00100);
        runCycles(1);
        applyStimulus(1'b0, 5'b00000, d, 1'b1);
        checkValue("t1 lane_start", 32'(bus0.LANE_START), 1);
        runCycles(1);
        checkValue("t1 out_valid", 32'(bus0.OUT_VALID), 1);
        checkValue("t1 out_id", 32'(bus0.OUT_ID), 2);
        checkValue("t1 out_data", 32'(bus0.OUT_DATA), 32'hC);
        runCycles(4);

        d = NREQ*WD'($urandom);
        applyStimulus(1'b0, 5'b10001, d, 1'b1);
        checkValue("t3 first grant dut0", 32'(bus0.IN_READY), 32'b10000);
        checkValue("t3 first grant dut1", 32'(bus1.IN_READY), 32'b10000);
        runCycles(3);
        checkValue("t3 wrap grant", 32'(bus0.IN_READY), 32'b00001);
        runCycles(5);
        applyStimulus(1'b0, 5'b00000, d, 1'b1);
        runCycles(8);

        applyStimulus(1'b1, '0, d, 1'b1);
        runCycles(2);
        d = NREQ*WD'($urandom);
        applyStimulus(1'b0, 5'b11111, d, 1'b1);
        grant_log.delete();
        runCycles(21);
        checkValue("t2 grant count", grant_log.size(), 7);
        for (int i = 0; i < 7 && i < grant_log.size(); i++) begin
            checkValue($sformatf("t2 grant order %0d", i), grant_log[i], exp_order[i]);
        end

        applyStimulus(1'b0, 5'b11111, d, 1'b0);
        runCycles(8);
        applyStimulus(1'b0, 5'b11111, d, 1'b1);
        runCycles(6);

        applyStimulus(1'b1, '0, d, 1'b1);
        runCycles(2);
        d = 20'h00050;
        applyStimulus(1'b0, 5'b00010, d, 1'b1);
        runCycles(1);
        applyStimulus(1'b0, 5'b00000, d, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            checkValue("t5 lane_in", 32'(bus1.LANE_IN), 5);
            checkValue("t5 lane_start", 32'(bus1.LANE_START), (c == 1) ? 1 : 0);
            runCycles(1);
        end
        checkValue("t5 out_valid", 32'(bus1.OUT_VALID), 1);
        checkValue("t5 out_data", 32'(bus1.OUT_DATA), 32'hA);
        runCycles(3);

        applyStimulus(1'b0, 5'b00010, d, 1'b1);
        runCycles(1);
        applyStimulus(1'b0, 5'b00000, d, 1'b1);
        runCycles(1);
        applyStimulus(1'b1, 5'b00000, d, 1'b1);
        runCycles(1);
        applyStimulus(1'b0, 5'b00000, d, 1'b1);
        checkValue("t6 out_valid", 32'(bus1.OUT_VALID), 0);
        checkValue("t6 lane_in", 32'(bus1.LANE_IN), 0);
        runCycles(5);
        applyStimulus(1'b0, 5'b11111, d, 1'b1);
        checkValue("t6 regrant dut0", 32'(bus0.IN_READY), 32'b00001);
        checkValue("t6 regrant dut1", 32'(bus1.IN_READY), 32'b00001);
        runCycles(4);

        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 49) == 0, NREQ'($urandom), NREQ*WD'($urandom),
                          $urandom_range(0, 3) != 0);
            runCycles(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_lane_scheduler.md
Name: rr_lane_scheduler

Overview:
Round-robin scheduler that shares one WD-bit transform lane among NREQ requesters. The lane is a SUB-style bit-chain transform instantiated outside this block.
- Each requester presents a word with a valid/ready handshake.
- The scheduler grants one requester, drives its word onto the lane, waits for the lane latency, and captures the result.
- The result is presented on a single output port tagged with the requester ID.
- It replaces the free-running input-select counter in front of the lane instances with a handshaked, fair arbiter.

Parameters:
NREQ, 5, number of requesters (2..16)
WD, 4, data width of each word and of the lane
IDW, 3, width of OUT_ID; must satisfy 2**IDW >= NREQ
LAT, 0, lane latency in cycles (0 = combinational lane, up to 7)

Ports:
CLK  in  1  clock; all logic on the rising edge
RST  in  1  synchronous active-high reset
IN_VALID  in  NREQ  per-requester valid; bit i belongs to requester i
IN_DATA  in  NREQ*WD  packed words; requester i uses bits [i*WD +: WD]
IN_READY  out  NREQ  one-hot grant; a transfer occurs when IN_VALID[i] & IN_READY[i]
LANE_IN  out  WD  word driven to the shared lane
LANE_START  out  1  one-cycle pulse in the first lane cycle
LANE_OUT  in  WD  lane result
OUT_VALID  out  1  result valid
OUT_ID  out  IDW  index of the requester that owns the result
OUT_DATA  out  WD  captured lane result
OUT_READY  in  1  downstream accept

Behaviour:
- FSM states: IDLE, ISSUE, HOLD. State, pointer and all data registers are registered.
- Reset (any state, any cycle):
  - state=IDLE, ptr=0, lat_cnt=0.
  - LANE_IN=0, LANE_START=0, OUT_VALID=0, OUT_ID=0, OUT_DATA=0.
  - IN_READY is forced to 0 while RST=1.
  - An in-flight transaction is silently dropped; nothing is replayed.
- IDLE:
  - g = first i with IN_VALID[i]=1, searching ptr, ptr+1, … NREQ-1, 0, … ptr-1.
  - IN_READY = onehot(g), driven combinationally; all zero if no IN_VALID bit is set, or if not in IDLE.
  - On transfer: lane_reg <= IN_DATA[g], id_reg <= g, ptr <= (g==NREQ-1) ? 0 : g+1, lat_cnt <= 0, state -> ISSUE.
- ISSUE:
  - LANE_IN = lane_reg, held stable for the whole state.
  - LANE_START=1 only in the first ISSUE cycle.
  - ISSUE lasts exactly LAT+1 cycles, counted by lat_cnt.
  - In the last ISSUE cycle: OUT_DATA <= LANE_OUT, OUT_ID <= id_reg, OUT_VALID <= 1, state -> HOLD.
- HOLD:
  - OUT_VALID, OUT_ID and OUT_DATA stay stable until OUT_READY=1.
  - On OUT_READY=1: OUT_VALID <= 0, state -> IDLE.
  - No new grant is issued in HOLD.
- Timing: with acceptance in cycle t, OUT_VALID is first high in cycle t+LAT+2. With OUT_READY held at 1, the grant-to-grant period is LAT+3 cycles.
- Fairness: a requester that holds IN_VALID is granted within NREQ grants.
- IN_VALID may drop without a transfer; no requester-side state is kept.
- OUT_READY is ignored outside HOLD.
- LANE_IN keeps its last value in IDLE and HOLD (0 after reset).
- Width rules:
  - ptr and OUT_ID are IDW bits; values >= NREQ never occur.
  - The ptr wrap is an explicit compare, not a power-of-two modulo.

Test Plan:
The bench lane model is LANE_OUT = LANE_IN ^ 4'hF, with LAT cycles of delay; NREQ=5, WD=4.
1. LAT=0, IN_VALID=5'b00100, IN_DATA[2]=4'h3, OUT_READY=1 -> IN_READY=5'b00100 in cycle 0; LANE_START in cycle 1; OUT_VALID=1, OUT_ID=2, OUT_DATA=4'hC in cycle 2; ptr=3.
2. IN_VALID=5'b11111 held, OUT_READY=1 -> grant order 0,1,2,3,4,0,1, one grant every 3 cycles; OUT_ID follows the same sequence.
3. After test 1 (ptr=3), IN_VALID=5'b10001 -> requester 4 is granted first, then requester 0 (ptr wraps 4 -> 0).
4. OUT_READY=0 for 5 cycles during HOLD with all IN_VALID=1 -> OUT_VALID/OUT_ID/OUT_DATA unchanged and IN_READY=0 throughout; after OUT_READY=1, the next grant comes 1 cycle later.
5. LAT=2 build, single request IN_DATA[1]=4'h5 -> ISSUE lasts 3 cycles with LANE_IN=4'h5 stable; OUT_VALID appears 4 cycles after acceptance with OUT_DATA=4'hA.
6. RST=1 pulsed in the second ISSUE cycle (LAT=2) -> next cycle state IDLE, OUT_VALID=0, ptr=0, LANE_IN=0, no result ever emitted; the next request with IN_VALID=5'b11111 grants requester 0.
